init_stream_unpacker: RTL and testbench

- Consumes the host initialization AXI-Stream (512-bit beats, each holding four 128-bit sub-packets, one per cell).
- Produces the per-cell init write bus that loads the position caches: address, position data, element and a per-step write enable.
- Sits directly upstream of the position-cache array and runs once per simulation before PE/MU start.

---
 rtl/init_stream_unpacker_pkg.sv | 40 ++++
 rtl/init_stream_unpacker.sv | 131 +++++++++++++
 tb/tb_init_stream_unpacker.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/init_stream_unpacker_pkg.sv
// Shared widths, init sub-packet layout and loader FSM encoding for the
// init stream unpacker.
package init_stream_unpacker_pkg;

  localparam int NUM_INIT_STEPS       = 7;
  localparam int NUM_SUB_PACKETS      = 4;
  localparam int NUM_CELLS            = NUM_INIT_STEPS * NUM_SUB_PACKETS;
  localparam int INIT_MAX_PARTICLES   = 15;
  localparam int PARTICLE_ID_WIDTH    = 4;
  localparam int STEP_WIDTH           = 3;
  localparam int POS_COORD_WIDTH      = 25;
  localparam int POS_STRUCT_WIDTH     = 3 * POS_COORD_WIDTH;
  localparam int ELEMENT_WIDTH        = 2;
  localparam int SUBPKT_WIDTH         = 128;
  localparam int BEAT_WIDTH           = SUBPKT_WIDTH * NUM_SUB_PACKETS;
  localparam int INIT_SUBPKT_POS_LSB  = 0;
  localparam int INIT_SUBPKT_ELEM_LSB = 75;

  typedef struct packed {
    logic [POS_COORD_WIDTH-1:0] pos_x;
    logic [POS_COORD_WIDTH-1:0] pos_y;
    logic [POS_COORD_WIDTH-1:0] pos_z;
  } pos_data_t;

  typedef logic [ELEMENT_WIDTH-1:0] element_t;

  // Reserved bits sit at the top so pos_data lands at bit 0 and element at 75.
  typedef struct packed {
    logic [50:0] reserved;
    element_t    element;
    pos_data_t   pos;
  } init_subpkt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/init_stream_unpacker.sv
// Unpacks the host init AXI-Stream (four 128-bit cell sub-packets per beat)
// into the per-cell position-cache write bus.
//
//   state | meaning
//   IDLE  | waiting for i_init_start, tready low
//   LOAD  | accepting beats, one cache write per matching beat
//   DONE  | stream finished (or ended early), tready low, o_init_done high
module init_stream_unpacker
  import init_stream_unpacker_pkg::*;
#(
  parameter logic [15:0] MY_TDEST      = 16'h0000,
  parameter int          MAX_PARTICLES = INIT_MAX_PARTICLES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_init_start,
  input  logic [BEAT_WIDTH-1:0]                 s_axis_tdata,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  input  logic [15:0]                           s_axis_tdest,
  output logic [PARTICLE_ID_WIDTH-1:0]          o_init_wr_addr,
  output logic [NUM_CELLS*POS_STRUCT_WIDTH-1:0] o_init_data,
  output logic [NUM_CELLS*ELEMENT_WIDTH-1:0]    o_init_element,
  output logic [NUM_INIT_STEPS-1:0]             o_init_wr_en,
  output logic                                  o_busy,
  output logic                                  o_init_done,
  output logic                                  o_err
);

  state_e                              state_q, state_d;
  logic [STEP_WIDTH-1:0]               step_q, step_d;
  logic [PARTICLE_ID_WIDTH-1:0]        part_q, part_d;
  logic                                err_q, err_d;
  logic [NUM_INIT_STEPS-1:0]           wr_en_q, wr_en_d;
  logic [PARTICLE_ID_WIDTH-1:0]        wr_addr_q, wr_addr_d;
  logic [NUM_CELLS*POS_STRUCT_WIDTH-1:0] data_q, data_d;
  logic [NUM_CELLS*ELEMENT_WIDTH-1:0]  elem_q, elem_d;

  init_subpkt_t                        subpkt [NUM_SUB_PACKETS];
  logic [NUM_SUB_PACKETS-1:0]          unused_rsvd;
  logic                                beat_match;
  logic                                last_beat;

  for (genvar k = 0; k < NUM_SUB_PACKETS; k++) begin : g_slice
    assign subpkt[k]      = init_subpkt_t'(s_axis_tdata[SUBPKT_WIDTH*k +: SUBPKT_WIDTH]);
    assign unused_rsvd[k] = ^subpkt[k].reserved;
  end

  assign beat_match = s_axis_tvalid && (s_axis_tdest == MY_TDEST);
  assign last_beat  = (part_q == PARTICLE_ID_WIDTH'(MAX_PARTICLES - 1)) &&
                      (step_q == STEP_WIDTH'(NUM_INIT_STEPS - 1));

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    part_d    = part_q;
    err_d     = err_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    data_d    = data_q;
    elem_d    = elem_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_init_start) begin
          state_d = ST_LOAD;
          step_d  = '0;
          part_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        // tready is constantly high here, so tvalid alone means accepted.
        if (beat_match) begin
          wr_en_d   = NUM_INIT_STEPS'(1) << step_q;
          wr_addr_d = part_q;
          for (int k = 0; k < NUM_SUB_PACKETS; k++) begin
            data_d[(NUM_SUB_PACKETS*int'(step_q) + k)*POS_STRUCT_WIDTH +: POS_STRUCT_WIDTH] =
              subpkt[k].pos;
            elem_d[(NUM_SUB_PACKETS*int'(step_q) + k)*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
              subpkt[k].element;
          end
          if (step_q == STEP_WIDTH'(NUM_INIT_STEPS - 1)) begin
            step_d = '0;
            part_d = part_q + 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
          // Early tlast and missing tlast on the final beat are both framing errors.
          if (last_beat || s_axis_tlast) begin
            state_d = ST_DONE;
            err_d   = err_q | (last_beat ^ s_axis_tlast);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      part_q    <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      data_q    <= '0;
      elem_q    <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      part_q    <= part_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      data_q    <= data_d;
      elem_q    <= elem_d;
    end
  end

  assign s_axis_tready  = (state_q == ST_LOAD);
  assign o_busy         = (state_q == ST_LOAD);
  assign o_init_done    = (state_q == ST_DONE);
  assign o_err          = err_q;
  assign o_init_wr_en   = wr_en_q;
  assign o_init_wr_addr = wr_addr_q;
  assign o_init_data    = data_q;
  assign o_init_element = elem_q;

endmodule

// File: tb/tb_init_stream_unpacker.sv
// Directed bench for init_stream_unpacker: expected cache writes are queued as
// beats are driven and checked, with a full per-cell model, when wr_en pulses.
module tb_init_stream_unpacker;
  import init_stream_unpacker_pkg::*;

  localparam int NC = NUM_CELLS;
  localparam int PW = POS_STRUCT_WIDTH;
  localparam int EW = ELEMENT_WIDTH;
  localparam int NS = NUM_INIT_STEPS;

  logic                     clk;
  logic                     rst;
  logic                     i_init_start;
  logic [BEAT_WIDTH-1:0]    s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic                     s_axis_tlast;
  logic [15:0]              s_axis_tdest;
  logic [PARTICLE_ID_WIDTH-1:0] o_init_wr_addr;
  logic [NC*PW-1:0]         o_init_data;
  logic [NC*EW-1:0]         o_init_element;
  logic [NS-1:0]            o_init_wr_en;
  logic                     o_busy;
  logic                     o_init_done;
  logic                     o_err;

  init_stream_unpacker dut (
    .clk            (clk),
    .rst            (rst),
    .i_init_start   (i_init_start),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tdest   (s_axis_tdest),
    .o_init_wr_addr (o_init_wr_addr),
    .o_init_data    (o_init_data),
    .o_init_element (o_init_element),
    .o_init_wr_en   (o_init_wr_en),
    .o_busy         (o_busy),
    .o_init_done    (o_init_done),
    .o_err          (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]         addr;
    logic [6:0]         wr_en;
    int                 step;
    logic [3:0][74:0]   pos;
    logic [3:0][1:0]    el;
  } exp_t;

  exp_t        sb[$];
  logic [PW-1:0] m_pos [NC];
  logic [EW-1:0] m_el  [NC];
  int total = 0;
  int bad   = 0;
  int n_wr  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cell c at particle p: pos_x = {c,p}; y and z are distinct per (c,p).
  function automatic logic [74:0] pos_of(input int c, input int p);
    logic [24:0] x, y, z;
    x = {16'd0, 5'(c), 4'(p)};
    y = 25'(c * 37 + p * 3);
    z = 25'h155555 ^ 25'(c << p);
    return {x, y, z};
  endfunction

  function automatic logic [1:0] el_of(input int c, input int p);
    return 2'(c + p);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst && o_init_wr_en != '0) begin
      n_wr++;
      if (sb.size() == 0) begin
        chk("unexpected_wr", 128'(o_init_wr_en), 128'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_en", 128'(o_init_wr_en), 128'(e.wr_en));
        chk("wr_addr", 128'(o_init_wr_addr), 128'(e.addr));
        for (int k = 0; k < 4; k++) begin
          m_pos[4*e.step + k] = e.pos[k];
          m_el[4*e.step + k]  = e.el[k];
        end
        for (int c = 0; c < NC; c++) begin
          chk($sformatf("data_cell%0d", c), 128'(o_init_data[c*PW +: PW]), 128'(m_pos[c]));
          chk($sformatf("elem_cell%0d", c), 128'(o_init_element[c*EW +: EW]), 128'(m_el[c]));
        end
      end
    end
  end

  task automatic send(input int p, input int s, input logic [15:0] dest,
                      input logic last, input bit push);
    logic [BEAT_WIDTH-1:0] d;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      d[128*k +: 128] = {51'({$urandom(), $urandom()}), el_of(4*s + k, p), pos_of(4*s + k, p)};
      e.pos[k] = pos_of(4*s + k, p);
      e.el[k]  = el_of(4*s + k, p);
    end
    e.addr  = 4'(p);
    e.wr_en = 7'(1 << s);
    e.step  = s;
    s_axis_tdata  = d;
    s_axis_tdest  = dest;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    chk("tready_load", 128'(s_axis_tready), 128'd1);
    if (push) sb.push_back(e);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic gap(input bit pulse_start);
    s_axis_tvalid = 1'b0;
    i_init_start  = pulse_start;
    @(negedge clk);
    i_init_start  = 1'b0;
    chk("gap_wr_en", 128'(o_init_wr_en), 128'd0);
  endtask

  task automatic stream(input int first, input int count, input int last_idx, input bit gapped);
    for (int b = first; b < first + count; b++) begin
      if (gapped && (b % 3 == 2)) gap(b == 41);
      send(b / NS, b % NS, 16'h0000, b == last_idx, 1'b1);
    end
  endtask

  task automatic start_load();
    i_init_start = 1'b1;
    @(negedge clk);
    i_init_start = 1'b0;
    chk("start_busy", 128'(o_busy), 128'd1);
    chk("start_done", 128'(o_init_done), 128'd0);
    chk("start_err", 128'(o_err), 128'd0);
  endtask

  task automatic finish_checks(input logic exp_err, input int exp_writes);
    @(negedge clk);
    #1;
    chk("end_done", 128'(o_init_done), 128'd1);
    chk("end_err", 128'(o_err), 128'(exp_err));
    chk("end_tready", 128'(s_axis_tready), 128'd0);
    chk("end_busy", 128'(o_busy), 128'd0);
    chk("end_wr_en", 128'(o_init_wr_en), 128'd0);
    chk("end_sb_empty", 128'(sb.size()), 128'd0);
    chk("end_n_writes", 128'(n_wr), 128'(exp_writes));
    n_wr = 0;
  endtask

  initial begin
    rst = 1'b0;
    i_init_start  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdest  = '0;
    for (int c = 0; c < NC; c++) begin
      m_pos[c] = '0;
      m_el[c]  = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_tready", 128'(s_axis_tready), 128'd0);
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_done", 128'(o_init_done), 128'd0);
    chk("rst_err", 128'(o_err), 128'd0);
    chk("rst_wr_en", 128'(o_init_wr_en), 128'd0);
    chk("rst_wr_addr", 128'(o_init_wr_addr), 128'd0);
    chk("rst_data_zero", 128'(|o_init_data), 128'd0);
    chk("rst_elem_zero", 128'(|o_init_element), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_tready", 128'(s_axis_tready), 128'd0);

    // Full load
    start_load();
    stream(0, 105, 104, 1'b0);
    finish_checks(1'b0, 105);

    // Gapped stream, with a start pulse in LOAD that must be ignored
    start_load();
    stream(0, 105, 104, 1'b1);
    finish_checks(1'b0, 105);

    // Wrong tdest beats mid-stream (one with tlast) are dropped
    start_load();
    stream(0, 40, -1, 1'b0);
    send(9, 3, 16'h0005, 1'b0, 1'b0);
    send(9, 4, 16'h0005, 1'b1, 1'b0);
    send(9, 5, 16'h0005, 1'b0, 1'b0);
    chk("drop_busy", 128'(o_busy), 128'd1);
    stream(40, 65, 104, 1'b0);
    finish_checks(1'b0, 105);

    // Early tlast on beat 20 (p=2, s=6)
    start_load();
    stream(0, 21, 20, 1'b0);
    finish_checks(1'b1, 21);
    s_axis_tvalid = 1'b1;
    chk("done_tready", 128'(s_axis_tready), 128'd0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("done_no_wr", 128'(o_init_wr_en), 128'd0);

    // Missing tlast
    start_load();
    stream(0, 105, -1, 1'b0);
    finish_checks(1'b1, 105);

    // Reset mid-load, then a clean reload
    start_load();
    stream(0, 50, -1, 1'b0);
    gap(1'b0);
    chk("pre_rst_writes", 128'(n_wr), 128'd50);
    n_wr = 0;
    rst = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_pos[c] = '0;
      m_el[c]  = '0;
    end
    #1;
    chk("midrst_busy", 128'(o_busy), 128'd0);
    chk("midrst_wr_addr", 128'(o_init_wr_addr), 128'd0);
    chk("midrst_data_zero", 128'(|o_init_data), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_en", 128'(o_init_wr_en), 128'd0);
    chk("post_rst_busy", 128'(o_busy), 128'd0);
    chk("post_rst_done", 128'(o_init_done), 128'd0);
    start_load();
    stream(0, 105, 104, 1'b0);
    finish_checks(1'b0, 105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
